// File: rtl/mem_rr_arbiter.sv
// Three-port round-robin arbiter sharing one memory port; responses are routed back to the owner.
// Optional watchdog abort is compiled in when MEM_ARB_TIMEOUT_EN is defined.
package mem_arb_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;
endpackage

module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  p0_in,
    output mem_out_type p0_out,
    input  mem_in_type  p1_in,
    output mem_out_type p1_out,
    input  mem_in_type  p2_in,
    output mem_out_type p2_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    mem_in_type  pending [3];
    mem_in_type  eff [3];
    logic [1:0]  last;
    logic [1:0]  sel;
    logic [1:0]  c1, c2;
    logic        any_valid;
    logic        done;
    logic        issue;
    logic        abort;
    mem_out_type resp;

    if ((2 ** CNT_W) < TIMEOUT_CYCLES) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    function automatic logic [1:0] rr_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    // Abort fires on the TIMEOUT_CYCLES-th BUSY cycle without a ready; a real ready always wins.
    assign abort = !reset && (state == BUSY) && !mem_out.mem_ready
                   && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || issue)
            cnt <= '0;
        else if (state == BUSY && !mem_out.mem_ready)
            cnt <= cnt + 1'b1;
    end
`else
    assign abort = 1'b0;
`endif

    assign timeout_err = abort;
    assign busy        = (state == BUSY);

    // Effective pending set includes this cycle's captures so an idle arbiter issues with zero latency.
    always_comb begin
        eff[0]    = p0_in.mem_valid ? p0_in : pending[0];
        eff[1]    = p1_in.mem_valid ? p1_in : pending[1];
        eff[2]    = p2_in.mem_valid ? p2_in : pending[2];
        done      = !reset && (state == BUSY) && (mem_out.mem_ready || abort);
        any_valid = eff[0].mem_valid || eff[1].mem_valid || eff[2].mem_valid;
        c1        = rr_inc(last);
        c2        = rr_inc(c1);
        if (eff[c1].mem_valid)
            sel = c1;
        else if (eff[c2].mem_valid)
            sel = c2;
        else
            sel = last;
        issue = !reset && any_valid && ((state == IDLE) || done);

        mem_in = init_mem_in;
        if (issue) begin
            mem_in           = eff[sel];
            mem_in.mem_valid = 1'b1;
        end

        resp = mem_out;
        if (abort) begin
            resp.mem_ready = 1'b1;
            resp.mem_rdata = '0;
        end
        p0_out = init_mem_out;
        p1_out = init_mem_out;
        p2_out = init_mem_out;
        if (done) begin
            case (grant_id)
                2'd0:    p0_out = resp;
                2'd1:    p1_out = resp;
                2'd2:    p2_out = resp;
                default: ;
            endcase
        end
    end

    // Captures persist until issued; completion either re-arbitrates immediately or returns to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            pending[0] <= init_mem_in;
            pending[1] <= init_mem_in;
            pending[2] <= init_mem_in;
            last       <= 2'd2;
            grant_id   <= 2'd3;
        end else begin
            pending[0] <= eff[0];
            pending[1] <= eff[1];
            pending[2] <= eff[2];
            if (issue) begin
                pending[sel] <= init_mem_in;
                last         <= sel;
                grant_id     <= sel;
                state        <= BUSY;
            end else if (done) begin
                state    <= IDLE;
                grant_id <= 2'd3;
            end
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: stimulus pushes expected issues/responses, a negedge monitor checks them.
// Timeout behaviour is checked against TIMEOUT_CYCLES = 8 when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_rr_arbiter;
    import mem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    mem_in_type  p0_in, p1_in, p2_in, mem_in;
    mem_out_type p0_out, p1_out, p2_out, mem_out;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] issue_q[$];
    logic [33:0] resp_q[$];

    mem_rr_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(9)) dut (
        .clock(clock), .reset(reset),
        .p0_in(p0_in), .p0_out(p0_out),
        .p1_in(p1_in), .p1_out(p1_out),
        .p2_in(p2_in), .p2_out(p2_out),
        .mem_in(mem_in), .mem_out(mem_out),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [33:0] actual, input logic [33:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] addr, input bit expect_issue);
        mem_in_type r;
        r           = '0;
        r.mem_valid = 1'b1;
        r.mem_addr  = addr;
        r.mem_wdata = ~addr;
        r.mem_wstrb = 4'hF;
        case (port)
            0:       p0_in = r;
            1:       p1_in = r;
            default: p2_in = r;
        endcase
        if (expect_issue) issue_q.push_back(addr);
    endtask

    task automatic respond(input logic [31:0] rdata, input logic [1:0] port, input bit expect_resp);
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = rdata;
        if (expect_resp) resp_q.push_back({port, rdata});
    endtask

    task automatic nextCycle;
        @(posedge clock);
        #1;
        p0_in   = '0;
        p1_in   = '0;
        p2_in   = '0;
        mem_out = '0;
    endtask

    // Monitor: every issued request and every owner response must match the head of its queue.
    always @(negedge clock) begin
        mem_out_type outs [3];
        logic [31:0] exp_addr;
        logic [33:0] exp_resp;
        if (!reset) begin
            if (mem_in.mem_valid) begin
                if (issue_q.size() == 0)
                    checkOutput("unexpected_issue", {2'b0, mem_in.mem_addr}, 34'h3_FFFF_FFFF);
                else begin
                    exp_addr = issue_q.pop_front();
                    checkOutput("issue_addr", {2'b0, mem_in.mem_addr}, {2'b0, exp_addr});
                end
            end
            outs = '{p0_out, p1_out, p2_out};
            for (int p = 0; p < 3; p++) begin
                if (outs[p].mem_ready) begin
                    if (resp_q.size() == 0)
                        checkOutput("unexpected_resp", {2'(p), outs[p].mem_rdata}, 34'h3_FFFF_FFFF);
                    else begin
                        exp_resp = resp_q.pop_front();
                        checkOutput("resp_port_data", {2'(p), outs[p].mem_rdata}, exp_resp);
                    end
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        p0_in   = '0;
        p1_in   = '0;
        p2_in   = '0;
        mem_out = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_busy", 34'(busy), 34'd0);
        checkOutput("rst_grant", 34'(grant_id), 34'd3);
        checkOutput("rst_timeout", 34'(timeout_err), 34'd0);
        checkOutput("rst_mem_valid", 34'(mem_in.mem_valid), 34'd0);
        checkOutput("rst_outs_ready", 34'({p0_out.mem_ready, p1_out.mem_ready, p2_out.mem_ready}), 34'd0);

        // Single p1 request, ready three cycles after issue
        applyStimulus(1, 32'h0000_0100, 1'b1);
        nextCycle;
        checkOutput("t1_busy", 34'(busy), 34'd1);
        checkOutput("t1_grant", 34'(grant_id), 34'd1);
        nextCycle;
        nextCycle;
        respond(32'hA1A1_0001, 2'd1, 1'b1);
        nextCycle;
        checkOutput("t1_busy_after", 34'(busy), 34'd0);
        checkOutput("t1_grant_after", 34'(grant_id), 34'd3);

        // Simultaneous requests after reset: order 0,1,2, back to back
        reset = 1'b1;
        nextCycle;
        reset = 1'b0;
        applyStimulus(0, 32'h0000_0010, 1'b1);
        applyStimulus(1, 32'h0000_0110, 1'b1);
        applyStimulus(2, 32'h0000_0210, 1'b1);
        nextCycle;
        checkOutput("t2_grant0", 34'(grant_id), 34'd0);
        respond(32'hB000_0000, 2'd0, 1'b1);
        nextCycle;
        checkOutput("t2_grant1", 34'(grant_id), 34'd1);
        respond(32'hB000_0001, 2'd1, 1'b1);
        nextCycle;
        checkOutput("t2_grant2", 34'(grant_id), 34'd2);
        respond(32'hB000_0002, 2'd2, 1'b1);
        nextCycle;
        checkOutput("t2_idle_grant", 34'(grant_id), 34'd3);
        checkOutput("t2_idle_busy", 34'(busy), 34'd0);

        // Fairness: re-requests in the owner's ready cycle rank last
        applyStimulus(0, 32'h0000_0200, 1'b1);
        applyStimulus(1, 32'h0000_0300, 1'b1);
        nextCycle;
        checkOutput("t3_grant_a", 34'(grant_id), 34'd0);
        respond(32'hC000_0000, 2'd0, 1'b1);
        applyStimulus(0, 32'h0000_0204, 1'b1);
        nextCycle;
        checkOutput("t3_grant_b", 34'(grant_id), 34'd1);
        respond(32'hC000_0001, 2'd1, 1'b1);
        applyStimulus(1, 32'h0000_0304, 1'b1);
        nextCycle;
        checkOutput("t3_grant_c", 34'(grant_id), 34'd0);
        respond(32'hC000_0002, 2'd0, 1'b1);
        nextCycle;
        checkOutput("t3_grant_d", 34'(grant_id), 34'd1);
        respond(32'hC000_0003, 2'd1, 1'b1);
        nextCycle;
        checkOutput("t3_idle", 34'(grant_id), 34'd3);

        // Spurious ready while idle
        respond(32'hDEAD_BEEF, 2'd0, 1'b0);
        #1;
        checkOutput("t4_outs_ready", 34'({p0_out.mem_ready, p1_out.mem_ready, p2_out.mem_ready}), 34'd0);
        checkOutput("t4_rdata0", 34'(p0_out.mem_rdata), 34'd0);
        nextCycle;
        checkOutput("t4_busy", 34'(busy), 34'd0);
        checkOutput("t4_grant", 34'(grant_id), 34'd3);

        // Reset while p2 owns the port, with p0 pending behind it
        applyStimulus(2, 32'h0000_0500, 1'b1);
        nextCycle;
        checkOutput("t5_grant2", 34'(grant_id), 34'd2);
        applyStimulus(0, 32'h0000_0600, 1'b0);
        nextCycle;
        reset = 1'b1;
        nextCycle;
        reset = 1'b0;
        #1;
        checkOutput("t5_busy", 34'(busy), 34'd0);
        checkOutput("t5_grant", 34'(grant_id), 34'd3);
        checkOutput("t5_pending_clear", 34'(mem_in.mem_valid), 34'd0);
        respond(32'h5555_AAAA, 2'd2, 1'b0);
        #1;
        checkOutput("t5_late_ready", 34'(p2_out.mem_ready), 34'd0);
        nextCycle;

        // Watchdog
        applyStimulus(0, 32'h0000_0700, 1'b1);
        nextCycle;
        checkOutput("t6_grant0", 34'(grant_id), 34'd0);
`ifdef MEM_ARB_TIMEOUT_EN
        checkOutput("t6_no_early_timeout", 34'(timeout_err), 34'd0);
        repeat (7) nextCycle;
        resp_q.push_back({2'd0, 32'h0});
        checkOutput("t6_timeout_err", 34'(timeout_err), 34'd1);
        nextCycle;
        checkOutput("t6_busy_after", 34'(busy), 34'd0);
        checkOutput("t6_grant_after", 34'(grant_id), 34'd3);
        respond(32'h7777_7777, 2'd0, 1'b0);
        #1;
        checkOutput("t6_late_ready", 34'(p0_out.mem_ready), 34'd0);
        nextCycle;
`else
        repeat (100) nextCycle;
        checkOutput("t6_still_busy", 34'(busy), 34'd1);
        checkOutput("t6_no_timeout", 34'(timeout_err), 34'd0);
        respond(32'hD700_0000, 2'd0, 1'b1);
        nextCycle;
        checkOutput("t6_busy_after", 34'(busy), 34'd0);
`endif

        repeat (2) nextCycle;
        checkOutput("issue_q_drained", 34'(issue_q.size()), 34'd0);
        checkOutput("resp_q_drained", 34'(resp_q.size()), 34'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
